// File: rtl/spi_txn_arbiter.sv
// ============================================================================
// spi_txn_arbiter: two-requester round-robin sequencer feeding multi-byte
// transactions to a single-CS SPI master one byte at a time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_txn_arbiter #(
  parameter int MAX_BYTES  = 2,
  parameter int CNT_W      = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_A_Req,
  input  logic [CNT_W-1:0]       i_A_Count,
  input  logic [MAX_BYTES*8-1:0] i_A_Data,
  output logic                   o_A_Gnt,
  output logic                   o_A_Done,
  input  logic                   i_B_Req,
  input  logic [CNT_W-1:0]       i_B_Count,
  input  logic [MAX_BYTES*8-1:0] i_B_Data,
  output logic                   o_B_Gnt,
  output logic                   o_B_Done,
  output logic [MAX_BYTES*8-1:0] o_RX_Word,
  output logic                   o_Busy,
  output logic                   o_Owner,
  output logic [CNT_W-1:0]       o_M_TX_Count,
  output logic [7:0]             o_M_TX_Byte,
  output logic                   o_M_TX_DV,
  input  logic                   i_M_TX_Ready,
  input  logic                   i_M_RX_DV,
  input  logic [7:0]             i_M_RX_Byte
);

  localparam int DW    = MAX_BYTES * 8;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_WAIT_RX = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [DW-1:0]    data;
  logic [GAP_W-1:0] gap;
  logic             rr_b;

  logic             any_req;
  logic             pick_b;
  logic [CNT_W-1:0] req_cnt;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] idx_inc;
  logic [7:0]       cur_byte;

  // B wins only when A is absent or A was the last one served.
  assign any_req = i_A_Req | i_B_Req;
  assign pick_b  = i_B_Req & (~i_A_Req | rr_b);
  assign req_cnt = pick_b ? i_B_Count : i_A_Count;
  assign eff_cnt = (req_cnt > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : req_cnt;
  assign idx_inc = idx + CNT_W'(1);

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx == CNT_W'(k)) cur_byte = data[8*k +: 8];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_req) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = (cnt == '0) ? S_FIN : S_SEND;
      S_SEND:    if (i_M_TX_Ready) state_nxt = S_WAIT_RX;
      S_WAIT_RX: if (i_M_RX_DV) state_nxt = (idx_inc == cnt) ? S_FIN : S_SEND;
      S_FIN:     state_nxt = S_GAP;
      S_GAP:     if (gap == '0) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_A_Gnt      <= 1'b0;
      o_B_Gnt      <= 1'b0;
      o_A_Done     <= 1'b0;
      o_B_Done     <= 1'b0;
      o_RX_Word    <= '0;
      o_Busy       <= 1'b0;
      o_Owner      <= 1'b0;
      o_M_TX_Count <= '0;
      o_M_TX_Byte  <= 8'h00;
      o_M_TX_DV    <= 1'b0;
      cnt          <= '0;
      idx          <= '0;
      data         <= '0;
      gap          <= '0;
      rr_b         <= 1'b0;
    end else begin
      o_A_Gnt   <= 1'b0;
      o_B_Gnt   <= 1'b0;
      o_A_Done  <= 1'b0;
      o_B_Done  <= 1'b0;
      o_M_TX_DV <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            o_A_Gnt   <= ~pick_b;
            o_B_Gnt   <= pick_b;
            o_Owner   <= pick_b;
            rr_b      <= ~pick_b;
            cnt       <= eff_cnt;
            data      <= pick_b ? i_B_Data : i_A_Data;
            o_RX_Word <= '0;
            o_Busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          o_M_TX_Count <= cnt;
          idx          <= '0;
        end
        S_SEND: begin
          if (i_M_TX_Ready) begin
            o_M_TX_DV   <= 1'b1;
            o_M_TX_Byte <= cur_byte;
          end
        end
        S_WAIT_RX: begin
          if (i_M_RX_DV) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (idx == CNT_W'(k)) o_RX_Word[8*k +: 8] <= i_M_RX_Byte;
            end
            idx <= idx_inc;
          end
        end
        S_FIN: begin
          o_A_Done <= ~o_Owner;
          o_B_Done <= o_Owner;
          gap      <= GAP_W'(GAP_CYCLES);
        end
        S_GAP: begin
          if (gap == '0) o_Busy <= 1'b0;
          else           gap    <= gap - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
